// File: rtl/pipeline_pkg.sv
// Shared pipeline widths and the default bubble instruction.
package pipeline_pkg;
  localparam int unsigned INSTR_W = 20;
  localparam int unsigned ADDR_W  = 20;
  localparam logic [INSTR_W-1:0] BUBBLE_INSTR_DEFAULT = 20'h00000;

  typedef logic [INSTR_W-1:0] instr_t;
  typedef logic [ADDR_W-1:0]  addr_t;
endpackage

// File: rtl/instruction_fifo.sv
// Power-of-two instruction storage with head/tail pointers and occupancy count.
module instruction_fifo
  import pipeline_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rstN,
  input  logic                   flush,
  input  logic                   push,
  input  instr_t                 pushData,
  input  logic                   pop,
  output instr_t                 headData,
  output logic [$clog2(DEPTH):0] count
);
  localparam int unsigned PW = $clog2(DEPTH);

  instr_t        mem [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[tail] <= pushData;
  end

  assign headData = mem[head];
endmodule

// File: rtl/instruction_prefetch_queue.sv
// Instruction prefetch queue: fetch PC, single-cycle memory handshake, redirect flush.
// Optional PREFETCH_BYPASS_EN forwards a response straight to DataIn when the queue is empty.
module instruction_prefetch_queue
  import pipeline_pkg::*;
#(
  parameter int unsigned DEPTH        = 4,
  parameter instr_t      BUBBLE_INSTR = BUBBLE_INSTR_DEFAULT
) (
  input  logic   Clock,
  input  logic   Reset,
  input  logic   JumpEnable,
  input  addr_t  JumpAddress,
  input  logic   Stall,
  output addr_t  IMem_Address,
  output logic   IMem_ReadEnable,
  input  instr_t IMem_DataIn,
  output instr_t DataIn,
  output logic   Instruction_Valid
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] DEPTH_V = (CW+1)'(DEPTH);

  addr_t         pc;
  logic          inflight;
  logic [CW-1:0] count;
  instr_t        headData;
  logic [CW:0]   occupancy;
  logic          discard;
  logic          respLive;
  logic          bypassHit;
  logic          push;
  logic          pop;
  logic          notEmpty;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      pc       <= '0;
      inflight <= 1'b0;
    end else begin
      if (JumpEnable)           pc <= JumpAddress;
      else if (IMem_ReadEnable) pc <= pc + 1'b1;
      inflight <= IMem_ReadEnable;
    end
  end

  // A response landing on the jump edge belongs to the old stream and is dropped.
  always_comb begin
    occupancy       = {1'b0, count} + {{CW{1'b0}}, inflight};
    IMem_ReadEnable = Reset && !JumpEnable && (occupancy < DEPTH_V);
    IMem_Address    = pc;
    notEmpty        = (count != '0);
    discard         = inflight && JumpEnable;
    respLive        = inflight && !discard;
    pop             = notEmpty && !Stall && !JumpEnable;
`ifdef PREFETCH_BYPASS_EN
    bypassHit         = respLive && !notEmpty;
    push              = respLive && !(bypassHit && !Stall);
    Instruction_Valid = notEmpty || bypassHit;
    DataIn            = notEmpty ? headData : (bypassHit ? IMem_DataIn : BUBBLE_INSTR);
`else
    bypassHit         = 1'b0;
    push              = respLive;
    Instruction_Valid = notEmpty;
    DataIn            = notEmpty ? headData : BUBBLE_INSTR;
`endif
  end

  instruction_fifo #(
    .DEPTH(DEPTH)
  ) uFifo (
    .clk      (Clock),
    .rstN     (Reset),
    .flush    (JumpEnable),
    .push     (push),
    .pushData (IMem_DataIn),
    .pop      (pop && !bypassHit),
    .headData (headData),
    .count    (count)
  );
endmodule

// File: tb/tb_instruction_prefetch_queue.sv
// Directed bench for instruction_prefetch_queue with a 1-cycle memory returning data = address.
module tb_instruction_prefetch_queue;
  import pipeline_pkg::*;

  localparam instr_t BUBBLE = 20'hBBBBB;
`ifdef PREFETCH_BYPASS_EN
  localparam int unsigned LAT  = 1;
  localparam int unsigned JLAT = 2;
`else
  localparam int unsigned LAT  = 2;
  localparam int unsigned JLAT = 3;
`endif

  logic   Clock = 1'b0;
  logic   Reset;
  logic   JumpEnable;
  addr_t  JumpAddress;
  logic   Stall;
  addr_t  IMem_Address;
  logic   IMem_ReadEnable;
  instr_t IMem_DataIn;
  instr_t DataIn;
  logic   Instruction_Valid;

  int checks = 0;
  int errors = 0;
  int reads;

  instruction_prefetch_queue #(
    .DEPTH(4),
    .BUBBLE_INSTR(BUBBLE)
  ) dut (
    .Clock             (Clock),
    .Reset             (Reset),
    .JumpEnable        (JumpEnable),
    .JumpAddress       (JumpAddress),
    .Stall             (Stall),
    .IMem_Address      (IMem_Address),
    .IMem_ReadEnable   (IMem_ReadEnable),
    .IMem_DataIn       (IMem_DataIn),
    .DataIn            (DataIn),
    .Instruction_Valid (Instruction_Valid)
  );

  always #5 Clock = ~Clock;

  always @(posedge Clock) begin
    if (IMem_ReadEnable) IMem_DataIn <= IMem_Address;
  end

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  // Checks k cycles from now: bubble before lat, then base, base+1, ...
  task automatic checkStream(input string tag, input addr_t base, input int unsigned lat,
                             input int unsigned n);
    instr_t exp;
    for (int unsigned k = 0; k < n; k++) begin
      checkVal({tag, "_valid"}, 32'(Instruction_Valid), 32'(k >= lat));
      if (k >= lat) exp = base + 20'(k - lat);
      else          exp = BUBBLE;
      checkVal({tag, "_data"}, 32'(DataIn), 32'(exp));
      step();
    end
  endtask

  task automatic jumpTo(input string tag, input addr_t target);
    JumpEnable  = 1'b1;
    JumpAddress = target;
    #1;
    checkVal({tag, "_ren_n"}, 32'(IMem_ReadEnable), 32'd0);
    step();
    JumpEnable = 1'b0;
    #1;
    checkVal({tag, "_addr"}, 32'(IMem_Address), 32'(target));
    checkVal({tag, "_ren"}, 32'(IMem_ReadEnable), 32'd1);
    checkStream(tag, target, JLAT - 1, 6);
  endtask

  initial begin
    Reset       = 1'b0;
    JumpEnable  = 1'b0;
    JumpAddress = '0;
    Stall       = 1'b0;
    repeat (2) step();
    #1;
    checkVal("rst_valid", 32'(Instruction_Valid), 32'd0);
    checkVal("rst_data", 32'(DataIn), 32'(BUBBLE));
    checkVal("rst_ren", 32'(IMem_ReadEnable), 32'd0);
    checkVal("rst_addr", 32'(IMem_Address), 32'd0);

    Reset = 1'b1;
    #1;
    checkVal("boot_addr", 32'(IMem_Address), 32'd0);
    checkVal("boot_ren", 32'(IMem_ReadEnable), 32'd1);
    checkStream("boot", 20'h00000, LAT, 10);

    // Restart under stall: the queue fills with exactly DEPTH reads.
    Reset = 1'b0;
    Stall = 1'b1;
    step();
    Reset = 1'b1;
    #1;
    reads = 0;
    for (int unsigned c = 0; c < 10; c++) begin
      if (IMem_ReadEnable) reads++;
      step();
    end
    checkVal("stall_reads", 32'(reads), 32'd4);
    checkVal("stall_ren", 32'(IMem_ReadEnable), 32'd0);
    checkVal("stall_valid", 32'(Instruction_Valid), 32'd1);
    checkVal("stall_hold", 32'(DataIn), 32'd0);
    Stall = 1'b0;
    #1;
    checkStream("drain", 20'h00000, 0, 8);

    jumpTo("jmp", 20'h00100);
    jumpTo("wrap", 20'hFFFFE);

    Stall = 1'b1;
    repeat (8) step();
    checkVal("full_valid", 32'(Instruction_Valid), 32'd1);
    checkVal("full_ren", 32'(IMem_ReadEnable), 32'd0);
    Reset = 1'b0;
    #1;
    checkVal("mid_rst_valid", 32'(Instruction_Valid), 32'd0);
    checkVal("mid_rst_data", 32'(DataIn), 32'(BUBBLE));
    checkVal("mid_rst_ren", 32'(IMem_ReadEnable), 32'd0);
    step();
    Reset = 1'b1;
    Stall = 1'b0;
    #1;
    checkVal("restart_addr", 32'(IMem_Address), 32'd0);
    checkVal("restart_ren", 32'(IMem_ReadEnable), 32'd1);
    checkStream("restart", 20'h00000, LAT, 6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
